// File: rtl/exe_stage_md.sv
// Execute stage: ALU, load/store address/lane generation, HI/LO multiply and iterative divide.
// Latency 1 cycle to out_valid; holds under out_ready=0; MD ops stall while the divider iterates.
module exe_stage_md #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_kind,
    input  logic [3:0]             in_fn,
    input  logic [XLEN-1:0]        in_src0,
    input  logic [XLEN-1:0]        in_src1,
    input  logic [XLEN-1:0]        in_sdata,
    input  logic [REGW-1:0]        in_regnum,
    input  logic                   in_wen,
    input  logic [XLEN-1:0]        in_pc,
    output logic                   dm_req,
    output logic [XLEN-1:0]        dm_addr,
    output logic [XLEN/8-1:0]      dm_we,
    output logic [XLEN-1:0]        dm_wdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_result,
    output logic [REGW-1:0]        out_regnum,
    output logic                   out_wen,
    output logic [XLEN-1:0]        out_pc,
    output logic                   out_exc,
    output logic [4:0]             out_exc_code,
    output logic                   div_busy
);
    localparam int LANES = XLEN / 8;
    localparam int SHW   = $clog2(XLEN);
    localparam int LW    = $clog2(LANES);

    localparam logic [1:0] K_ALU   = 2'd0;
    localparam logic [1:0] K_LOAD  = 2'd1;
    localparam logic [1:0] K_STORE = 2'd2;
    localparam logic [1:0] K_MD    = 2'd3;

    logic w_is_md, w_is_mem, w_accept, w_md_acc;
    assign w_is_md  = (in_kind == K_MD);
    assign w_is_mem = (in_kind == K_LOAD) || (in_kind == K_STORE);
    assign in_ready = (!out_valid || out_ready) && !(w_is_md && div_busy);
    assign w_accept = in_valid && in_ready && !flush;
    assign w_md_acc = w_accept && w_is_md;

    // ALU
    logic [XLEN-1:0] w_sum, w_diff, w_alu;
    logic [SHW-1:0]  w_sh;
    logic            w_ov;
    assign w_sum  = in_src0 + in_src1;
    assign w_diff = in_src0 - in_src1;
    assign w_sh   = in_src0[SHW-1:0];

    always_comb begin
        w_alu = '0;
        w_ov  = 1'b0;
        case (in_fn)
            4'd0: begin
                w_alu = w_sum;
                w_ov  = (in_src0[XLEN-1] == in_src1[XLEN-1]) && (w_sum[XLEN-1] != in_src0[XLEN-1]);
            end
            4'd1: w_alu = w_sum;
            4'd2: begin
                w_alu = w_diff;
                w_ov  = (in_src0[XLEN-1] != in_src1[XLEN-1]) && (w_diff[XLEN-1] != in_src0[XLEN-1]);
            end
            4'd3:  w_alu = w_diff;
            4'd4:  w_alu = in_src0 & in_src1;
            4'd5:  w_alu = in_src0 | in_src1;
            4'd6:  w_alu = in_src0 ^ in_src1;
            4'd7:  w_alu = ~(in_src0 | in_src1);
            4'd8:  w_alu = {{(XLEN-1){1'b0}}, ($signed(in_src0) < $signed(in_src1))};
            4'd9:  w_alu = {{(XLEN-1){1'b0}}, (in_src0 < in_src1)};
            4'd10: w_alu = in_src1 << w_sh;
            4'd11: w_alu = in_src1 >> w_sh;
            4'd12: w_alu = $signed(in_src1) >>> w_sh;
            4'd13: w_alu = in_src1 << (XLEN / 2);
            default: w_alu = '0;
        endcase
    end

    // Load/store: size is 1<<fn[1:0] bytes; anything wider than a word is misaligned
    logic [31:0]      w_bytes, w_bmask;
    logic             w_misal;
    logic [LANES-1:0] w_lmask;
    assign w_bytes = 32'd1 << in_fn[1:0];
    assign w_bmask = w_bytes - 32'd1;
    assign w_misal = (w_bytes > 32'(LANES)) || ((32'(w_sum[LW-1:0]) & w_bmask) != 32'd0);

    always_comb begin
        w_lmask  = '0;
        dm_wdata = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lmask[i]         = (i < int'(w_bytes));
            dm_wdata[8*i +: 8] = in_sdata[8*(i & int'(w_bmask)) +: 8];
        end
    end

    assign dm_req  = w_accept && w_is_mem && !w_misal;
    assign dm_addr = w_sum;
    assign dm_we   = (dm_req && (in_kind == K_STORE)) ? (w_lmask << w_sum[LW-1:0]) : '0;

    // Multiply
    logic [XLEN-1:0]   r_hi, r_lo;
    logic [2*XLEN-1:0] w_prod_s, w_prod_u, w_prod;
    assign w_prod_s = $signed({{XLEN{in_src0[XLEN-1]}}, in_src0}) * $signed({{XLEN{in_src1[XLEN-1]}}, in_src1});
    assign w_prod_u = {{XLEN{1'b0}}, in_src0} * {{XLEN{1'b0}}, in_src1};
    assign w_prod   = in_fn[0] ? w_prod_u : w_prod_s;

    // Restoring divider on magnitudes; signs are re-applied on the final edge
    logic            r_div_busy, r_neg_q, r_neg_r, r_dz;
    logic [SHW-1:0]  r_div_cnt;
    logic [XLEN-1:0] r_rem, r_quo, r_dvs;
    logic [XLEN:0]   w_shift;
    logic            w_take;
    logic [XLEN-1:0] w_rem_nx, w_quo_nx, w_q_fin, w_r_fin;
    logic            w_a_neg, w_b_neg;

    assign w_shift  = {r_rem, r_quo[XLEN-1]};
    assign w_take   = (w_shift >= {1'b0, r_dvs});
    assign w_rem_nx = w_take ? (w_shift[XLEN-1:0] - r_dvs) : w_shift[XLEN-1:0];
    assign w_quo_nx = {r_quo[XLEN-2:0], w_take};
    assign w_q_fin  = r_dz ? '1 : (r_neg_q ? -w_quo_nx : w_quo_nx);
    assign w_r_fin  = r_neg_r ? -w_rem_nx : w_rem_nx;
    assign w_a_neg  = !in_fn[0] && in_src0[XLEN-1];
    assign w_b_neg  = !in_fn[0] && in_src1[XLEN-1];
    assign div_busy = r_div_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_busy <= 1'b0;
            r_div_cnt  <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
        end else begin
            if (flush) begin
                r_div_busy <= 1'b0;
            end else if (r_div_busy) begin
                r_rem     <= w_rem_nx;
                r_quo     <= w_quo_nx;
                r_div_cnt <= r_div_cnt - 1'b1;
                if (r_div_cnt == '0) begin
                    r_div_busy <= 1'b0;
                    r_hi       <= w_r_fin;
                    r_lo       <= w_q_fin;
                end
            end
            if (w_md_acc) begin
                case (in_fn)
                    4'd0, 4'd1: {r_hi, r_lo} <= w_prod;
                    4'd2, 4'd3: begin
                        r_div_busy <= 1'b1;
                        r_div_cnt  <= SHW'(XLEN - 1);
                        r_rem      <= '0;
                        r_quo      <= w_a_neg ? -in_src0 : in_src0;
                        r_dvs      <= w_b_neg ? -in_src1 : in_src1;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_dz       <= (in_src1 == '0);
                    end
                    4'd6: r_hi <= in_src0;
                    4'd7: r_lo <= in_src0;
                    default: ;
                endcase
            end
        end
    end

    // Result and exception selection
    logic [XLEN-1:0] w_result;
    logic            w_exc;
    logic [4:0]      w_exc_code;

    always_comb begin
        w_result   = '0;
        w_exc      = 1'b0;
        w_exc_code = 5'd0;
        case (in_kind)
            K_ALU: begin
                w_result   = w_alu;
                w_exc      = w_ov;
                w_exc_code = w_ov ? 5'd12 : 5'd0;
            end
            K_LOAD: begin
                w_result   = w_sum;
                w_exc      = w_misal;
                w_exc_code = w_misal ? 5'd4 : 5'd0;
            end
            K_STORE: begin
                w_result   = w_sum;
                w_exc      = w_misal;
                w_exc_code = w_misal ? 5'd5 : 5'd0;
            end
            default: begin
                if (in_fn == 4'd4)      w_result = r_hi;
                else if (in_fn == 4'd5) w_result = r_lo;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_regnum   <= '0;
            out_wen      <= 1'b0;
            out_pc       <= '0;
            out_exc      <= 1'b0;
            out_exc_code <= 5'd0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_accept) begin
            out_valid    <= 1'b1;
            out_result   <= w_result;
            out_regnum   <= in_regnum;
            out_wen      <= in_wen && !w_exc;
            out_pc       <= in_pc;
            out_exc      <= w_exc;
            out_exc_code <= w_exc_code;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_exe_stage_md.sv
// Directed bench for exe_stage_md: ALU, load/store lanes, MD unit, backpressure and flush.
module tb_exe_stage_md;
    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam logic [1:0] ALU = 2'd0, LD = 2'd1, ST = 2'd2, MD = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, flush, in_valid, in_ready, in_wen;
    logic [1:0]       in_kind;
    logic [3:0]       in_fn;
    logic [XLEN-1:0]  in_src0, in_src1, in_sdata, in_pc;
    logic [REGW-1:0]  in_regnum;
    logic             dm_req;
    logic [XLEN-1:0]  dm_addr, dm_wdata;
    logic [3:0]       dm_we;
    logic             out_valid, out_ready, out_wen, out_exc, div_busy;
    logic [XLEN-1:0]  out_result, out_pc;
    logic [REGW-1:0]  out_regnum;
    logic [4:0]       out_exc_code;

    exe_stage_md #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_fn(in_fn),
        .in_src0(in_src0), .in_src1(in_src1), .in_sdata(in_sdata),
        .in_regnum(in_regnum), .in_wen(in_wen), .in_pc(in_pc),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_regnum(out_regnum), .out_wen(out_wen), .out_pc(out_pc),
        .out_exc(out_exc), .out_exc_code(out_exc_code), .div_busy(div_busy)
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [XLEN-1:0] pc_next = 32'h0000_4000;
    logic [XLEN-1:0] last_pc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [1:0] k, input logic [3:0] fn, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] sd, input logic [4:0] rn);
        in_valid  = 1'b1;
        in_kind   = k;
        in_fn     = fn;
        in_src0   = a;
        in_src1   = b;
        in_sdata  = sd;
        in_regnum = rn;
        in_wen    = 1'b1;
        in_pc     = pc_next;
        last_pc   = pc_next;
        pc_next   = pc_next + 32'd4;
    endtask

    task automatic idle;
        in_valid = 1'b0;
    endtask

    task automatic run(input string tag, input logic [1:0] k, input logic [3:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                       input logic exc, input logic [4:0] code);
        op(k, fn, a, b, 32'h0, 5'd7);
        tick;
        idle;
        check({tag, "_vld"}, out_valid, 1);
        check({tag, "_res"}, out_result, exp);
        check({tag, "_exc"}, out_exc, exc);
        check({tag, "_code"}, out_exc_code, code);
        check({tag, "_wen"}, out_wen, !exc);
        check({tag, "_pc"}, out_pc, last_pc);
    endtask

    task automatic wait_div;
        int c;
        c = 0;
        while (div_busy && c < 200) begin
            tick;
            c++;
        end
        check("div_done", div_busy, 0);
    endtask

    task automatic div_case(input string tag, input logic [3:0] fn, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] q, input logic [31:0] r);
        op(MD, fn, a, b, 32'h0, 5'd0);
        tick;
        idle;
        wait_div;
        run({tag, "_lo"}, MD, 4'd5, 0, 0, q, 0, 0);
        run({tag, "_hi"}, MD, 4'd4, 0, 0, r, 0, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c;
        bit  stall_ok;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_kind = '0; in_fn = '0; in_src0 = '0; in_src1 = '0; in_sdata = '0;
        in_regnum = '0; in_wen = 1'b0; in_pc = '0;
        tick; tick;
        check("rst_vld", out_valid, 0);
        check("rst_res", out_result, 0);
        check("rst_rn", out_regnum, 0);
        check("rst_wen", out_wen, 0);
        check("rst_pc", out_pc, 0);
        check("rst_exc", out_exc, 0);
        check("rst_code", out_exc_code, 0);
        check("rst_busy", div_busy, 0);
        rst_n = 1'b1;
        run("rst_hi", MD, 4'd4, 0, 0, 32'h0, 0, 0);
        run("rst_lo", MD, 4'd5, 0, 0, 32'h0, 0, 0);

        // ALU
        run("add_ov", ALU, 4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 5'd12);
        run("addu", ALU, 4'd1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 0);
        run("sub_ov", ALU, 4'd2, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1, 5'd12);
        run("sub", ALU, 4'd2, 32'h5, 32'h7, 32'hFFFF_FFFE, 0, 0);
        run("subu", ALU, 4'd3, 32'h3, 32'h5, 32'hFFFF_FFFE, 0, 0);
        run("and", ALU, 4'd4, 32'hF0F0, 32'hFF00, 32'hF000, 0, 0);
        run("or", ALU, 4'd5, 32'hF0F0, 32'hFF00, 32'hFFF0, 0, 0);
        run("xor", ALU, 4'd6, 32'hF0F0, 32'hFF00, 32'h0FF0, 0, 0);
        run("nor", ALU, 4'd7, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, 0);
        run("slt", ALU, 4'd8, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 0);
        run("sltu", ALU, 4'd9, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 0);
        run("sll_wrap", ALU, 4'd10, 32'h21, 32'h1, 32'h2, 0, 0);
        run("srl", ALU, 4'd11, 32'h4, 32'h8000_0000, 32'h0800_0000, 0, 0);
        run("sra", ALU, 4'd12, 32'h4, 32'h8000_0000, 32'hF800_0000, 0, 0);
        run("lui", ALU, 4'd13, 32'h0, 32'h1234, 32'h1234_0000, 0, 0);
        run("fn14", ALU, 4'd14, 32'h5, 32'h6, 32'h0, 0, 0);

        // Load/store lanes and alignment
        op(ST, 4'd1, 32'h1000, 32'h2, 32'hAABB_CCDD, 5'd0);
        #2;
        check("sh_req", dm_req, 1);
        check("sh_addr", dm_addr, 32'h1002);
        check("sh_we", dm_we, 4'b1100);
        check("sh_wdata", dm_wdata, 32'hCCDD_CCDD);
        tick;
        check("sh_res", out_result, 32'h1002);
        check("sh_exc", out_exc, 0);
        op(ST, 4'd1, 32'h1000, 32'h1, 32'hAABB_CCDD, 5'd0);
        #2;
        check("sh_mis_req", dm_req, 0);
        check("sh_mis_we", dm_we, 0);
        tick;
        check("sh_mis_exc", out_exc, 1);
        check("sh_mis_code", out_exc_code, 5'd5);
        check("sh_mis_wen", out_wen, 0);
        op(LD, 4'd2, 32'h1000, 32'h2, 32'h0, 5'd0);
        #2;
        check("lw_mis_req", dm_req, 0);
        tick;
        check("lw_mis_code", out_exc_code, 5'd4);
        op(LD, 4'd0, 32'h1000, 32'h3, 32'h0, 5'd0);
        #2;
        check("lb_req", dm_req, 1);
        check("lb_we", dm_we, 0);
        tick;
        check("lb_exc", out_exc, 0);
        check("lb_res", out_result, 32'h1003);
        op(ST, 4'd0, 32'h1000, 32'h3, 32'hAABB_CCDD, 5'd0);
        #2;
        check("sb_we", dm_we, 4'b1000);
        check("sb_wdata", dm_wdata, 32'hDDDD_DDDD);
        tick;
        op(ST, 4'd2, 32'h1000, 32'h4, 32'hAABB_CCDD, 5'd0);
        #2;
        check("sw_we", dm_we, 4'b1111);
        check("sw_wdata", dm_wdata, 32'hAABB_CCDD);
        tick;
        op(ST, 4'd3, 32'h1000, 32'h0, 32'hAABB_CCDD, 5'd0);
        #2;
        check("sd_req", dm_req, 0);
        tick;
        check("sd_code", out_exc_code, 5'd5);
        idle;

        // Multiply, back-to-back reads
        op(MD, 4'd0, 32'hFFFF_FFFF, 32'h2, 32'h0, 5'd0);
        tick;
        run("mult_hi", MD, 4'd4, 0, 0, 32'hFFFF_FFFF, 0, 0);
        run("mult_lo", MD, 4'd5, 0, 0, 32'hFFFF_FFFE, 0, 0);
        op(MD, 4'd1, 32'hFFFF_FFFF, 32'h2, 32'h0, 5'd0);
        tick;
        run("multu_hi", MD, 4'd4, 0, 0, 32'h1, 0, 0);

        // DIV -7/2 with MFLO stalled behind it
        op(MD, 4'd2, 32'hFFFF_FFF9, 32'h2, 32'h0, 5'd0);
        tick;
        check("div_out_vld", out_valid, 1);
        check("div_busy_on", div_busy, 1);
        op(MD, 4'd5, 0, 0, 32'h0, 5'd9);
        c = 0;
        stall_ok = 1'b1;
        #1;
        while (div_busy && c < 100) begin
            if (in_ready) stall_ok = 1'b0;
            tick;
            #1;
            c++;
        end
        check("div_busy_cycles", c, 32);
        check("div_stall", stall_ok, 1);
        check("mflo_ready", in_ready, 1);
        tick;
        idle;
        check("div_lo", out_result, 32'hFFFF_FFFD);
        check("div_lo_rn", out_regnum, 5'd9);
        run("div_hi", MD, 4'd4, 0, 0, 32'hFFFF_FFFF, 0, 0);

        // DIVU by zero with ALU traffic flowing during busy
        op(MD, 4'd3, 32'h5, 32'h0, 32'h0, 5'd0);
        tick;
        op(ALU, 4'd1, 32'h1, 32'h2, 32'h0, 5'd4);
        #1;
        check("busy_alu_rdy", in_ready, 1);
        tick;
        idle;
        check("busy_alu_vld", out_valid, 1);
        check("busy_alu_res", out_result, 32'h3);
        check("busy_alu_busy", div_busy, 1);
        wait_div;
        run("divu0_lo", MD, 4'd5, 0, 0, 32'hFFFF_FFFF, 0, 0);
        run("divu0_hi", MD, 4'd4, 0, 0, 32'h5, 0, 0);
        div_case("div0", 4'd2, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        div_case("divmin", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
        div_case("divneg", 4'd2, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1);
        div_case("divu", 4'd3, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF);

        // Backpressure: A held, B waits, then both emerge in order
        op(ALU, 4'd1, 32'd10, 32'd1, 32'h0, 5'd1);
        tick;
        out_ready = 1'b0;
        op(ALU, 4'd1, 32'd20, 32'd2, 32'h0, 5'd2);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_rdy", in_ready, 0);
            check("bp_vld", out_valid, 1);
            check("bp_res", out_result, 32'd11);
            check("bp_rn", out_regnum, 5'd1);
            tick;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", in_ready, 1);
        tick;
        idle;
        check("bp_b_res", out_result, 32'd22);
        check("bp_b_rn", out_regnum, 5'd2);
        tick;
        check("bp_drained", out_valid, 0);

        // Flush clears a held output
        op(ALU, 4'd1, 32'd1, 32'd1, 32'h0, 5'd3);
        tick;
        idle;
        out_ready = 1'b0;
        tick;
        check("fl_hold_vld", out_valid, 1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        out_ready = 1'b1;
        check("fl_hold_clr", out_valid, 0);

        // Flush aborts a divide in its 10th busy cycle and blocks the accept
        run("mthi", MD, 4'd6, 32'h111, 0, 32'h0, 0, 0);
        run("mtlo", MD, 4'd7, 32'h222, 0, 32'h0, 0, 0);
        op(MD, 4'd2, 32'd100, 32'd7, 32'h0, 5'd0);
        tick;
        idle;
        repeat (9) tick;
        check("fl_div_busy", div_busy, 1);
        flush = 1'b1;
        op(ALU, 4'd1, 32'd5, 32'd5, 32'h0, 5'd5);
        tick;
        flush = 1'b0;
        idle;
        check("fl_div_abort", div_busy, 0);
        check("fl_div_vld", out_valid, 0);
        run("fl_hi", MD, 4'd4, 0, 0, 32'h111, 0, 0);
        run("fl_lo", MD, 4'd5, 0, 0, 32'h222, 0, 0);
        flush = 1'b1;
        op(MD, 4'd6, 32'h999, 0, 32'h0, 5'd0);
        tick;
        flush = 1'b0;
        idle;
        check("fl_mthi_vld", out_valid, 0);
        run("fl_mthi_hi", MD, 4'd4, 0, 0, 32'h111, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/exe_stage_md.md
# exe_stage_md

Parametrised execute stage with a valid/ready pipeline register, an integrated ALU, load/store address and lane generation with alignment exceptions, and a HI/LO multiply/divide unit with an iterative divider. It sits between decode/regfile-read and the memory/writeback stage. It drives the data-memory request combinationally on the accept cycle and registers results for writeback.

## Interface
- XLEN, 32: datapath width; multiple of 8, ≥16, power of two.
- REGW, 5: destination register index width.
- LANES, XLEN/8: derived, not overridable; byte lanes per memory word.

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  kill the accept-cycle op, the output register and any running divide
- in_valid  in  1  upstream op valid
- in_ready  out  1  stage can accept
- in_kind  in  2  0 ALU, 1 LOAD, 2 STORE, 3 MD
- in_fn  in  4  sub-function (see Operation)
- in_src0, in_src1  in  XLEN  operands
- in_sdata  in  XLEN  store data
- in_regnum  in  REGW  destination register
- in_wen  in  1  writes register
- in_pc  in  XLEN  op PC
- dm_req  out  1  memory request, combinational
- dm_addr  out  XLEN  src0+src1
- dm_we  out  LANES  store byte enables; 0 for loads
- dm_wdata  out  XLEN  store data, lane-replicated
- out_valid  out  1  output register valid
- out_ready  in  1  downstream accepts
- out_result  out  XLEN  ALU result, address, or MFHI/MFLO value
- out_regnum  out  REGW
- out_wen  out  1  forced 0 when out_exc=1
- out_pc  out  XLEN
- out_exc  out  1  exception flagged
- out_exc_code  out  5  4 AdEL, 5 AdES, 12 Ov
- div_busy  out  1  divider iterating

## Operation
- Accept means in_valid & in_ready & !flush.
- in_ready = (!out_valid | out_ready) & !(in_kind==MD & div_busy).
- ALU in_fn:
  - 0 ADD (Ov trap), 1 ADDU, 2 SUB (Ov trap), 3 SUBU
  - 4 AND, 5 OR, 6 XOR, 7 NOR
  - 8 SLT, 9 SLTU
  - 10 SLL, 11 SRL, 12 SRA: src1 shifted by src0[log2(XLEN)-1:0]
  - 13 LUI: src1 << XLEN/2
  - 14-15 give 0
- Signed overflow sets code 12; the result is still registered.
- LOAD/STORE: in_fn[1:0]=log2(access bytes).
  - An access is misaligned when addr mod bytes ≠ 0, or the size exceeds LANES.
  - Misaligned → exc code 4 (load) or 5 (store); dm_req=0, dm_we=0.
  - dm_req=1 only on an accepted, aligned memory op.
  - dm_we = ((1<<bytes)-1) << addr[log2(LANES)-1:0].
  - dm_wdata = low (8·bytes) bits of in_sdata replicated across the word.
  - out_result = address.
- MD in_fn:
  - 0 MULT, 1 MULTU: full 2·XLEN product; HI/LO written on the accept edge.
  - 2 DIV, 3 DIVU: operands latched; div_busy=1 for exactly XLEN cycles; HI=remainder, LO=quotient written on the final edge.
  - 4 MFHI, 5 MFLO: out_result=HI/LO.
  - 6 MTHI, 7 MTLO: write src0.
  - 8-15: no-op, result 0.
- Signed divide rules:
  - Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - MIN/−1 gives quotient MIN, remainder 0.
  - Divide by zero gives quotient all-ones and remainder = dividend, both signed and unsigned.
- A DIV op itself passes to the output register at accept; it needs no wait.
- Non-MD ops continue to flow while div_busy=1.
- flush:
  - Clears out_valid next edge and blocks the accept that cycle.
  - Aborts the divider with div_busy→0; HI/LO unchanged.
  - MULT/MT* writes in the flush cycle are suppressed.

## Timing
- Reset values:
  - out_valid=0, out_result=0, out_regnum=0, out_wen=0, out_pc=0, out_exc=0, out_exc_code=0
  - HI=LO=0, div_busy=0
  - Reset aborts a running divide.
- Latency: 1 cycle from accept to out_valid.
- The output register holds while out_valid & !out_ready.
- Accept and drain in the same cycle is allowed, giving full throughput.
- MFHI right after MULT returns the new value; there is no hazard.
- An MD op arriving while div_busy stalls until the edge on which div_busy falls; it is accepted the following cycle and sees the new HI/LO.
- dm_* are valid only in the accept cycle and are not held during out stall.

## Test plan
- ADD 0x7FFFFFFF+1 → out_exc=1, code 12, out_wen=0; ADDU same operands → result 0x80000000, out_wen=1.
- STORE half at addr 0x1002, sdata 0xAABBCCDD → dm_we=4'b1100, dm_wdata=0xCCDDCCDD; half at 0x1001 → code 5, dm_req=0.
- DIV −7/2, then MFLO, MFHI → div_busy high for 32 cycles; MFLO stalls, then returns 0xFFFFFFFD; MFHI returns 0xFFFFFFFF.
- DIVU 5/0 → LO=0xFFFFFFFF, HI=5; a subsequent ADDU issued during busy completes with 1-cycle latency.
- out_ready held low 3 cycles with a second op pending → in_ready=0; out fields stable; both ops emerge in order.
- flush at cycle 10 of a DIV → div_busy=0 next cycle, HI/LO keep prior values, out_valid=0.
